im_port_arbiter: RTL and testbench

Shares the single combinational instruction-memory read port between two requesters.
- Fetch requester: the F-stage PC.
- Debug requester: a debug/loader port used for instruction readback.

The block arbitrates between them, range- and alignment-checks the address, and registers the returned word with one-cycle latency. It sits between the F stage and the instruction ROM and also handles F-stage flush squashing.

---
 rtl/im_arb_pkg.sv | 17 +
 rtl/im_addr_check.sv | 19 +
 rtl/im_port_arbiter.sv | 108 ++++++++++
 tb/tb_im_port_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/im_arb_pkg.sv
// Shared constants and types for the instruction-memory port arbiter.
// Holds requester indices, default ROM geometry and the registered response record.
package im_arb_pkg;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
  localparam int          IM_DEPTH     = 4096;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

endpackage

// File: rtl/im_addr_check.sv
// Range and word-alignment check of a byte address against the ROM window.
// Latency: combinational. Backpressure: none.
module im_addr_check #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 4096
) (
  input  logic [31:0] addr,
  output logic        ok
);

  // Span kept at 33 bits so a window reaching the top of the address space cannot wrap.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  logic [31:0] offset;

  assign offset = addr - BASE_ADDR;
  assign ok     = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);

endmodule

// File: rtl/im_port_arbiter.sv
// Arbitrates fetch and debug reads onto one combinational ROM port; IM_ARB_RR_EN selects round-robin.
// Latency: grant same cycle, response registered one cycle later. Backpressure: none, responses must be taken.
// Default build is fixed fetch priority with a starvation override for debug.
module im_port_arbiter
  import im_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = IM_BASE_ADDR,
  parameter int          DEPTH        = IM_DEPTH,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        f_flush,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr
);

  logic  f_req_eff;
  logic  addr_ok;
  resp_t f_resp;
  resp_t d_resp;

  // A flushed fetch never competes, so debug can use the slot.
  assign f_req_eff = f_req & ~f_flush;

`ifdef IM_ARB_RR_EN
  logic last_grant;

  assign d_gnt = d_req & (~f_req_eff | (last_grant == REQ_F));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_F;
    end else if (d_gnt) begin
      last_grant <= REQ_D;
    end else if (f_gnt) begin
      last_grant <= REQ_F;
    end
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;

  assign d_gnt = d_req & ((starve_cnt == CW'(STARVE_LIMIT)) | ~f_req_eff);

  // Counts consecutive cycles debug asked and lost; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!d_req || d_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  assign f_gnt   = f_req_eff & ~d_gnt;
  assign im_addr = d_gnt ? d_addr : (f_gnt ? f_addr : BASE_ADDR);

  im_addr_check #(
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH)
  ) u_addr_check (
    .addr(im_addr),
    .ok  (addr_ok)
  );

  // Data only updates on a grant; the idle requester keeps its last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_resp <= '0;
      d_resp <= '0;
    end else begin
      f_resp.valid <= f_gnt;
      f_resp.err   <= f_gnt & ~addr_ok;
      if (f_gnt) begin
        f_resp.data <= addr_ok ? im_instr : 32'h0;
      end
      d_resp.valid <= d_gnt;
      d_resp.err   <= d_gnt & ~addr_ok;
      if (d_gnt) begin
        d_resp.data <= addr_ok ? im_instr : 32'h0;
      end
    end
  end

  assign f_rvalid = f_resp.valid;
  assign f_rdata  = f_resp.data;
  assign f_err    = f_resp.err;
  assign d_rvalid = d_resp.valid;
  assign d_rdata  = d_resp.data;
  assign d_err    = d_resp.err;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter (default build): directed vectors, per-cycle model comparison
// plus hand-computed literal checks.
module tb_im_port_arbiter;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 4096;
  localparam int          LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0;
  logic [31:0] f_addr = 32'h0, d_addr = 32'h0;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
  logic [31:0] f_rdata, d_rdata, im_addr, im_instr;

  int vectors = 0;
  int miscompares = 0;

  im_port_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .im_addr(im_addr), .im_instr(im_instr)
  );

  always #5 clk = ~clk;

  // ROM contents: word 1 is a fixed instruction, every other word is derived from its index.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    if (idx == 32'd1) return 32'h2408_0001;
    return {16'hC0DE ^ idx[15:0], idx[15:0]};
  endfunction

  assign im_instr = rom_word(im_addr);

  function automatic bit addr_ok(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua % 4 == 0) && (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: expected responses pending and debug's consecutive-loss count.
  bit          m_f_vld, m_f_err, m_d_vld, m_d_err;
  logic [31:0] m_f_dat, m_d_dat;
  int          m_starve;

  always @(negedge clk) begin
    bit          eg_f, eg_d, f_live;
    logic [31:0] e_addr;
    if (reset) begin
      m_f_vld = 0; m_f_err = 0; m_f_dat = 0;
      m_d_vld = 0; m_d_err = 0; m_d_dat = 0;
      m_starve = 0;
      check("rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);
      check("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
      check("rst_f_rdata", f_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
    end else begin
      check("m_f_rvalid", {31'b0, f_rvalid}, {31'b0, m_f_vld});
      check("m_f_rdata", f_rdata, m_f_dat);
      if (m_f_vld) check("m_f_err", {31'b0, f_err}, {31'b0, m_f_err});
      check("m_d_rvalid", {31'b0, d_rvalid}, {31'b0, m_d_vld});
      check("m_d_rdata", d_rdata, m_d_dat);
      if (m_d_vld) check("m_d_err", {31'b0, d_err}, {31'b0, m_d_err});

      f_live = f_req && !f_flush;
      eg_d   = d_req && (m_starve == LIMIT || !f_live);
      eg_f   = f_live && !eg_d;
      e_addr = eg_d ? d_addr : (eg_f ? f_addr : BASE);
      check("m_f_gnt", {31'b0, f_gnt}, {31'b0, eg_f});
      check("m_d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
      check("m_im_addr", im_addr, e_addr);

      m_f_vld = eg_f;
      if (eg_f) begin
        m_f_err = !addr_ok(f_addr);
        m_f_dat = addr_ok(f_addr) ? rom_word(f_addr) : 32'h0;
      end
      m_d_vld = eg_d;
      if (eg_d) begin
        m_d_err = !addr_ok(d_addr);
        m_d_dat = addr_ok(d_addr) ? rom_word(d_addr) : 32'h0;
      end
      if (d_req && !eg_d) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
    end
  end

  // Drive one cycle's inputs just after the rising edge.
  task automatic cyc(input logic fr, input logic [31:0] fa, input logic ff,
                     input logic dr, input logic [31:0] da);
    @(posedge clk);
    #1;
    f_req = fr; f_addr = fa; f_flush = ff; d_req = dr; d_addr = da;
  endtask

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        ff;
    logic        dr;
    logic [31:0] da;
  } vec_t;

  vec_t tbl[10];
  logic [5:0] fg, dg;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h0000_2FFC, 1'b0, 1'b1, 32'h0000_3010};
    tbl[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_6FFC};
    tbl[3] = '{1'b1, 32'h0000_3008, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'h0000_300C, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_3020};
    tbl[6] = '{1'b1, 32'h0000_3001, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_3000};
    tbl[8] = '{1'b1, 32'h0000_3004, 1'b1, 1'b1, 32'h0000_3004};
    tbl[9] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First fetch of ROM word 1.
    cyc(1'b1, 32'h0000_3004, 1'b0, 1'b0, 32'h0);
    #1 check("f_gnt_first", {31'b0, f_gnt}, 32'h1);
    check("im_addr_first", im_addr, 32'h0000_3004);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f_rvalid_first", {31'b0, f_rvalid}, 32'h1);
    check("f_rdata_first", f_rdata, 32'h2408_0001);
    check("f_err_first", {31'b0, f_err}, 32'h0);

    // Both requesting for six cycles: debug wins only after four losses.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, BASE + 32'(4 * i), 1'b0, 1'b1, 32'h0000_3040);
      #1 fg[i] = f_gnt;
      dg[i] = d_gnt;
    end
    check("starve_f_pattern", {26'b0, fg}, 32'h0000_002F);
    check("starve_d_pattern", {26'b0, dg}, 32'h0000_0010);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Misaligned, then first address past the window.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3002);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_7000);
    check("mis_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    check("mis_d_err", {31'b0, d_err}, 32'h1);
    check("mis_d_rdata", d_rdata, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("oor_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    check("oor_d_err", {31'b0, d_err}, 32'h1);
    check("oor_d_rdata", d_rdata, 32'h0);

    // Flushed fetch yields the port to debug.
    cyc(1'b1, 32'h0000_3004, 1'b1, 1'b1, 32'h0000_3008);
    #1 check("flush_f_gnt", {31'b0, f_gnt}, 32'h0);
    check("flush_d_gnt", {31'b0, d_gnt}, 32'h1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("flush_f_rvalid", {31'b0, f_rvalid}, 32'h0);
    check("flush_d_rvalid", {31'b0, d_rvalid}, 32'h1);

    // A flush does not kill a response already presented.
    cyc(1'b1, 32'h0000_3010, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h0000_3014, 1'b1, 1'b0, 32'h0);
    check("flush_prev_rvalid", {31'b0, f_rvalid}, 32'h1);

    foreach (tbl[i]) cyc(tbl[i].fr, tbl[i].fa, tbl[i].ff, tbl[i].dr, tbl[i].da);

    // Asynchronous reset right after a granted cycle's response appears.
    cyc(1'b1, 32'h0000_3018, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1 check("pre_rst_f_rvalid", {31'b0, f_rvalid}, 32'h1);
    f_req = 1'b0;
    #1 reset = 1'b1;
    #1 check("async_rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);
    check("async_rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("post_rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);
    check("post_rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
